multisim_push_arb: RTL
======================

# multisim_push_arb

Round-robin arbiter that shares one `multisim_server_push` channel among `NUM_REQ` emulator-side requesters. Each requester presents a valid/ready/data stream. The arbiter picks one beat per cycle, registers it, and drives the push server's `data_vld`/`data` with the winning requester's index attached so the host-side client can demultiplex. It sits in `top` between local producers and a single push server instance, saving one server/socket per producer.

## Interface
- `NUM_REQ`, default 4: number of requesters, 1..16.
- `DATA_WIDTH`, default 64: payload width per beat.
- `ID_WIDTH`, default `$clog2(NUM_REQ)` (min 1): width of `out_id`; derived, not overridden.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `req_vld`  in  NUM_REQ  per-requester beat valid
- `req_rdy`  out  NUM_REQ  per-requester accept; at most one bit high per cycle
- `req_data`  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_last`  in  NUM_REQ  last beat of packet; used only with `MULTISIM_ARB_PKT_EN`
- `out_vld`  out  1  to push server `data_vld`
- `out_rdy`  in  1  from push server `data_rdy`
- `out_data`  out  DATA_WIDTH  to push server `data` (low bits)
- `out_id`  out  ID_WIDTH  winning requester index (concatenated above `out_data` at instantiation)

## Operation
- Single output register (`out_vld`, `out_data`, `out_id`).
- `load = !out_vld || out_rdy`.
- Round-robin pointer `ptr` (ID_WIDTH bits). Grant `g` is the first `i` with `req_vld[i]`, scanning `ptr, ptr+1, …` modulo `NUM_REQ`.
- `req_rdy[g] = load`; all other `req_rdy` bits are 0.
- `req_rdy` may depend combinationally on `req_vld`; requesters must not make `req_vld` depend on `req_rdy`.
- Accept on `req_vld[g] && req_rdy[g]`:
  - output register loads `req_data[g]`, `g`;
  - `out_vld` is set;
  - `ptr` becomes `g+1`, wrapping to 0 at `NUM_REQ` (also when `NUM_REQ` is not a power of two).
- No accept while `load` is high: `out_vld` clears, `ptr` holds.
- `out_vld && !out_rdy`: `out_data`/`out_id` held stable and `out_vld` stays high until taken. No beat is ever dropped or duplicated.
- `NUM_REQ=1`: degenerates to a registered pass-through, `out_id` is always 0.

## Timing
- Reset values (and every cycle `rst` is high): `out_vld=0`, `out_data=0`, `out_id=0`, `ptr=0`, packet state IDLE.
- `req_rdy` is forced to all-zero while `rst` is high.
- Latency: a beat accepted in cycle t appears on `out_vld` in cycle t+1.
- Throughput: one beat per cycle when `out_rdy` stays high.
- Simultaneous drain and load in the same cycle is allowed, giving full throughput.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0,…
- Any single requester waits at most `NUM_REQ-1` accepted beats of other requesters (packet mode: `NUM_REQ-1` packets).
- Reset mid-operation: a pending output beat is discarded and any lock is released. Requesters restart from `ptr=0`.

## Configuration
- `MULTISIM_ARB_PKT_EN` defined: packet mode, implemented as an FSM with states IDLE and LOCKED.
  - IDLE: normal round-robin.
  - Accepted beat with `req_last[g]=0`: go to LOCKED, `lock_id<=g`, `ptr` unchanged.
  - LOCKED: only `lock_id` may be granted; other `req_vld` are ignored even if the locked requester is idle.
  - Accepted beat from `lock_id` with `req_last=1`: go to IDLE, `ptr<=lock_id+1` (wrap).
  - A single-beat packet (`req_last=1` on the first beat) stays in IDLE.
- Macro undefined: `req_last` is ignored, there is no FSM, and arbitration is per beat. The port still exists so the interface is identical in both builds.

## Test plan
- Reset: hold `rst` 3 cycles with all `req_vld=1` -> `req_rdy=0`, `out_vld=0`, `out_data=0`, `out_id=0`. The first grant after reset goes to requester 0.
- Full contention: `NUM_REQ=4`, all valid, `out_rdy=1`, data `i*0x100+n` -> `out_id` sequence 0,1,2,3,0,… one per cycle, each `out_data` appearing 1 cycle after its accept.
- Backpressure: `out_rdy=0` for 5 cycles with beat `0xDEADBEEF` from requester 2 registered -> `out_data`/`out_id` stable and every `req_rdy=0`. On `out_rdy=1` the beat is taken once, and the next beat loads in the same cycle.
- Wrap, non-power-of-two: `NUM_REQ=3`, only requesters 2 and 0 valid -> grants alternate 2,0,2,0; `ptr` wraps 2->0.
- Sparse: only requester 1 valid, for 10 beats -> ten consecutive `out_id=1` beats, no bubbles.
- Packet mode (`MULTISIM_ARB_PKT_EN`): requester 3 sends 4 beats (`req_last` on the 4th) while 0 and 1 are valid -> `out_id` 3,3,3,3, then 0, then 1. Asserting `rst` after beat 2 -> lock released, next grant goes to 0.

Source files
------------

// File: rtl/multisim_push_arb.sv
// Round-robin arbiter sharing one push-server channel among NUM_REQ valid/ready requesters.
// Optional packet mode (hold the grant until req_last) is enabled with `define MULTISIM_ARB_PKT_EN.
module multisim_push_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 64,
    localparam int unsigned ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_vld,
    output logic [NUM_REQ-1:0]            req_rdy,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [ID_WIDTH-1:0]           out_id
);

    logic                  load;
    logic                  found;
    logic                  accept;
    logic [ID_WIDTH-1:0]   gnt;
    logic [ID_WIDTH-1:0]   gnt_inc;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  gnt_last;
    logic [ID_WIDTH-1:0]   ptr_q;
    logic [ID_WIDTH-1:0]   ptr_d;

`ifdef MULTISIM_ARB_PKT_EN
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ID_WIDTH-1:0] lock_q;
    logic [ID_WIDTH-1:0] lock_d;
`endif

    assign load   = !out_vld || out_rdy;
    assign accept = found && load && !rst;

    // Winner: first valid at or after ptr, then wrap to those below ptr.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_vld[i] && (i >= int'(ptr_q))) begin
                found = 1'b1;
                gnt   = ID_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_vld[i] && (i < int'(ptr_q))) begin
                found = 1'b1;
                gnt   = ID_WIDTH'(i);
            end
        end
`ifdef MULTISIM_ARB_PKT_EN
        // A locked packet owns the channel even while its source is idle.
        if (state_q == LOCKED) begin
            found = 1'b0;
            gnt   = lock_q;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ID_WIDTH'(i) == lock_q) begin
                    found = req_vld[i];
                end
            end
        end
`endif
    end

    // Payload, last flag and ready for the granted lane.
    always_comb begin
        gnt_data = '0;
        gnt_last = 1'b0;
        req_rdy  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_WIDTH'(i) == gnt) begin
                gnt_data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                gnt_last   = req_last[i];
                req_rdy[i] = found && load && !rst;
            end
        end
    end

    // Explicit wrap so non-power-of-two NUM_REQ never points past the last requester.
    assign gnt_inc = (32'(gnt) == NUM_REQ - 1) ? '0 : gnt + ID_WIDTH'(1);

`ifdef MULTISIM_ARB_PKT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    // Pointer only advances when a packet completes.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        if (accept) begin
            if (gnt_last) begin
                state_d = IDLE;
                ptr_d   = gnt_inc;
            end else begin
                state_d = LOCKED;
                lock_d  = gnt;
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = gnt_last;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = gnt_inc;
        end
    end
`endif

    // Output register: loads on accept, holds while stalled, empties when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
            out_id   <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (load) begin
                out_vld <= accept;
            end
            if (accept) begin
                out_data <= gnt_data;
                out_id   <= gnt;
            end
        end
    end

endmodule
